// File: rtl/trap_csr_sequencer.sv
// M-mode trap entry / mret return sequencer that owns the CSR file write port and read address.
// Optional feature macro: TRAP_SEQ_MTVAL_EN (adds the mtval write to trap entry).
module trap_csr_sequencer #(
  parameter int unsigned XLEN = 2,      // XLEN_64b: data width W = 1 << (XLEN + 4)
  parameter logic [3:0]  NO_E = 4'hF    // exception code meaning "no exception"
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_clk_en,
  input  logic [3:0]                     i_exception_code_f_d_ff,
  input  logic [(1 << (XLEN + 4))-1:0]   i_exception_pc_f_d_ff,
  input  logic [3:0]                     i_exception_code_e_m_ff,
  input  logic [(1 << (XLEN + 4))-1:0]   i_exception_pc_e_m_ff,
  input  logic [(1 << (XLEN + 4))-1:0]   i_exception_addr_e_m_ff,
  input  logic                           i_mret_e,
  input  logic                           i_csr_req,
  input  logic                           i_csr_req_we,
  input  logic [11:0]                    i_csr_req_addr,
  input  logic [(1 << (XLEN + 4))-1:0]   i_csr_req_wdata,
  output logic                           o_csr_gnt,
  output logic [(1 << (XLEN + 4))-1:0]   o_csr_req_rdata,
  output logic [11:0]                    o_csr_read_addr,
  input  logic [(1 << (XLEN + 4))-1:0]   i_csr_rdata,
  output logic [11:0]                    o_csr_write_addr,
  output logic                           o_csr_we,
  output logic [(1 << (XLEN + 4))-1:0]   o_csr_wdata,
  output logic                           o_busy,
  output logic                           o_redirect_valid,
  output logic [(1 << (XLEN + 4))-1:0]   o_redirect_pc
);

  localparam int unsigned W = 1 << (XLEN + 4);

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMtvec   = 12'h305;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;
`ifdef TRAP_SEQ_MTVAL_EN
  localparam logic [11:0] AddrMtval   = 12'h343;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StTMepc,
    StTMcause,
`ifdef TRAP_SEQ_MTVAL_EN
    StTMtval,
`endif
    StTMstatus,
    StRMepc,
    StRMstatus,
    StRedirect
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cause_q, cause_d;
  logic [W-1:0]   epc_q, epc_d;
  logic [W-1:0]   target_q, target_d;
  logic           is_mret_q, is_mret_d;
`ifdef TRAP_SEQ_MTVAL_EN
  logic [W-1:0]   tval_q, tval_d;
`else
  logic           unused_addr;
  assign unused_addr = ^i_exception_addr_e_m_ff;
`endif

  logic           em_exc, fd_exc;
  logic [W-1:0]   mstatus_trap, mstatus_ret;

  assign em_exc          = (i_exception_code_e_m_ff != NO_E);
  assign fd_exc          = (i_exception_code_f_d_ff != NO_E);
  assign o_csr_req_rdata = i_csr_rdata;

  // mstatus images for trap entry and mret, built from the live read of 0x300
  always_comb begin
    mstatus_trap         = i_csr_rdata;
    mstatus_trap[7]      = i_csr_rdata[3];
    mstatus_trap[3]      = 1'b0;
    mstatus_trap[12:11]  = 2'b11;
    mstatus_ret          = i_csr_rdata;
    mstatus_ret[3]       = i_csr_rdata[7];
    mstatus_ret[7]       = 1'b1;
    mstatus_ret[12:11]   = 2'b11;
  end

  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    epc_d            = epc_q;
    target_d         = target_q;
    is_mret_d        = is_mret_q;
`ifdef TRAP_SEQ_MTVAL_EN
    tval_d           = tval_q;
`endif
    o_csr_gnt        = 1'b0;
    o_csr_read_addr  = '0;
    o_csr_write_addr = '0;
    o_csr_we         = 1'b0;
    o_csr_wdata      = '0;
    o_busy           = (state_q != StIdle);
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;

    unique case (state_q)
      StIdle: begin
        if (em_exc) begin
          o_busy    = 1'b1;
          cause_d   = i_exception_code_e_m_ff;
          epc_d     = i_exception_pc_e_m_ff;
`ifdef TRAP_SEQ_MTVAL_EN
          tval_d    = i_exception_addr_e_m_ff;
`endif
          is_mret_d = 1'b0;
          state_d   = StTMepc;
        end else if (i_mret_e) begin
          o_busy    = 1'b1;
          is_mret_d = 1'b1;
          state_d   = StRMepc;
        end else if (fd_exc) begin
          o_busy    = 1'b1;
          cause_d   = i_exception_code_f_d_ff;
          epc_d     = i_exception_pc_f_d_ff;
`ifdef TRAP_SEQ_MTVAL_EN
          tval_d    = i_exception_pc_f_d_ff;
`endif
          is_mret_d = 1'b0;
          state_d   = StTMepc;
        end else if (i_csr_req) begin
          o_csr_gnt        = 1'b1;
          o_csr_read_addr  = i_csr_req_addr;
          o_csr_write_addr = i_csr_req_addr;
          o_csr_we         = i_csr_req_we;
          o_csr_wdata      = i_csr_req_wdata;
        end
      end
      StTMepc: begin
        o_csr_write_addr = AddrMepc;
        o_csr_we         = 1'b1;
        o_csr_wdata      = {epc_q[W-1:1], 1'b0};
        state_d          = StTMcause;
      end
      StTMcause: begin
        o_csr_write_addr = AddrMcause;
        o_csr_we         = 1'b1;
        o_csr_wdata      = {{(W-4){1'b0}}, cause_q};
`ifdef TRAP_SEQ_MTVAL_EN
        state_d          = StTMtval;
`else
        state_d          = StTMstatus;
`endif
      end
`ifdef TRAP_SEQ_MTVAL_EN
      StTMtval: begin
        o_csr_write_addr = AddrMtval;
        o_csr_we         = 1'b1;
        o_csr_wdata      = tval_q;
        state_d          = StTMstatus;
      end
`endif
      StTMstatus: begin
        o_csr_read_addr  = AddrMstatus;
        o_csr_write_addr = AddrMstatus;
        o_csr_we         = 1'b1;
        o_csr_wdata      = mstatus_trap;
        state_d          = StRedirect;
      end
      StRMepc: begin
        o_csr_read_addr  = AddrMepc;
        target_d         = {i_csr_rdata[W-1:1], 1'b0};
        state_d          = StRMstatus;
      end
      StRMstatus: begin
        o_csr_read_addr  = AddrMstatus;
        o_csr_write_addr = AddrMstatus;
        o_csr_we         = 1'b1;
        o_csr_wdata      = mstatus_ret;
        state_d          = StRedirect;
      end
      StRedirect: begin
        o_redirect_valid = 1'b1;
        if (is_mret_q) begin
          o_redirect_pc  = target_q;
        end else begin
          // trap vector is sampled live so a prior write to mtvec is honoured
          o_csr_read_addr = AddrMtvec;
          o_redirect_pc   = {i_csr_rdata[W-1:2], 2'b00};
        end
        state_d          = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // reset aborts the sequence before anything else commits
    if (i_rst) begin
      o_csr_we         = 1'b0;
      o_redirect_valid = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cause_q   <= '0;
      epc_q     <= '0;
      target_q  <= '0;
      is_mret_q <= 1'b0;
`ifdef TRAP_SEQ_MTVAL_EN
      tval_q    <= '0;
`endif
    end else if (i_clk_en) begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      target_q  <= target_d;
      is_mret_q <= is_mret_d;
`ifdef TRAP_SEQ_MTVAL_EN
      tval_q    <= tval_d;
`endif
    end
  end

endmodule

// File: tb/tb_trap_csr_sequencer.sv
// Bench for trap_csr_sequencer: CSR file model, directed test-plan steps and random transactions
// checked against a transaction-level reference model.
module tb_trap_csr_sequencer;

  localparam int unsigned W    = 64;
  localparam logic [3:0]  NO_E = 4'hF;
`ifdef TRAP_SEQ_MTVAL_EN
  localparam bit MtvalEn = 1'b1;
`else
  localparam bit MtvalEn = 1'b0;
`endif
  localparam int TrapLen = MtvalEn ? 5 : 4;
  localparam int MretLen = 3;

  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MSCR    = 12'h340;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;
  localparam logic [11:0] MTVAL   = 12'h343;

  logic         i_clk = 1'b0;
  logic         i_rst, i_clk_en;
  logic [3:0]   i_exception_code_f_d_ff, i_exception_code_e_m_ff;
  logic [W-1:0] i_exception_pc_f_d_ff, i_exception_pc_e_m_ff, i_exception_addr_e_m_ff;
  logic         i_mret_e, i_csr_req, i_csr_req_we;
  logic [11:0]  i_csr_req_addr;
  logic [W-1:0] i_csr_req_wdata;
  logic         o_csr_gnt;
  logic [W-1:0] o_csr_req_rdata;
  logic [11:0]  o_csr_read_addr, o_csr_write_addr;
  logic [W-1:0] i_csr_rdata;
  logic         o_csr_we;
  logic [W-1:0] o_csr_wdata;
  logic         o_busy, o_redirect_valid;
  logic [W-1:0] o_redirect_pc;

  int n_chk = 0;
  int n_fail = 0;

  trap_csr_sequencer u_dut (
    .i_clk                   (i_clk),
    .i_rst                   (i_rst),
    .i_clk_en                (i_clk_en),
    .i_exception_code_f_d_ff (i_exception_code_f_d_ff),
    .i_exception_pc_f_d_ff   (i_exception_pc_f_d_ff),
    .i_exception_code_e_m_ff (i_exception_code_e_m_ff),
    .i_exception_pc_e_m_ff   (i_exception_pc_e_m_ff),
    .i_exception_addr_e_m_ff (i_exception_addr_e_m_ff),
    .i_mret_e                (i_mret_e),
    .i_csr_req               (i_csr_req),
    .i_csr_req_we            (i_csr_req_we),
    .i_csr_req_addr          (i_csr_req_addr),
    .i_csr_req_wdata         (i_csr_req_wdata),
    .o_csr_gnt               (o_csr_gnt),
    .o_csr_req_rdata         (o_csr_req_rdata),
    .o_csr_read_addr         (o_csr_read_addr),
    .i_csr_rdata             (i_csr_rdata),
    .o_csr_write_addr        (o_csr_write_addr),
    .o_csr_we                (o_csr_we),
    .o_csr_wdata             (o_csr_wdata),
    .o_busy                  (o_busy),
    .o_redirect_valid        (o_redirect_valid),
    .o_redirect_pc           (o_redirect_pc)
  );

  always #5 i_clk = ~i_clk;

  // CSR file: combinational read, write ignored while the clock enable is low
  logic [W-1:0] csr_mem [4096];
  assign i_csr_rdata = csr_mem[o_csr_read_addr];
  always @(posedge i_clk) begin
    if (o_csr_we && i_clk_en) csr_mem[o_csr_write_addr] <= o_csr_wdata;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference mstatus updates: clear MIE/MPIE/MPP then rebuild them
  function automatic logic [W-1:0] trap_ms(input logic [W-1:0] s);
    return (s & ~64'h1888) | (((s >> 3) & 64'd1) << 7) | 64'h1800;
  endfunction

  function automatic logic [W-1:0] ret_ms(input logic [W-1:0] s);
    return (s & ~64'h1888) | (((s >> 7) & 64'd1) << 3) | 64'h0080 | 64'h1800;
  endfunction

  task automatic clear_inputs();
    i_exception_code_f_d_ff = NO_E;
    i_exception_code_e_m_ff = NO_E;
    i_exception_pc_f_d_ff   = '0;
    i_exception_pc_e_m_ff   = '0;
    i_exception_addr_e_m_ff = '0;
    i_mret_e                = 1'b0;
    i_csr_req               = 1'b0;
    i_csr_req_we            = 1'b0;
    i_csr_req_addr          = '0;
    i_csr_req_wdata         = '0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [W-1:0] d);
    csr_mem[a] <= d;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic do_txn(
    input logic [3:0]   em_code,
    input logic [W-1:0] em_pc,
    input logic [W-1:0] em_addr,
    input logic         mret,
    input logic [3:0]   fd_code,
    input logic [W-1:0] fd_pc,
    input logic         req,
    input logic         req_we,
    input logic [11:0]  req_addr,
    input logic [W-1:0] req_wdata,
    input int           stall_at,
    input int           stall_len
  );
    logic [W-1:0] e_mepc, e_mcause, e_mtval, e_mstatus, e_pc, old_req;
    int kind, lat, c;
    e_mepc    = csr_mem[MEPC];
    e_mcause  = csr_mem[MCAUSE];
    e_mtval   = csr_mem[MTVAL];
    e_mstatus = csr_mem[MSTATUS];
    old_req   = csr_mem[req_addr];
    e_pc      = '0;
    lat       = 0;
    if (em_code != NO_E) begin
      kind      = 0;
      e_mepc    = em_pc & ~64'd1;
      e_mcause  = 64'(em_code);
      if (MtvalEn) e_mtval = em_addr;
      e_mstatus = trap_ms(e_mstatus);
      e_pc      = csr_mem[MTVEC] & ~64'd3;
      lat       = TrapLen;
    end else if (mret) begin
      kind      = 1;
      e_pc      = e_mepc & ~64'd1;
      e_mstatus = ret_ms(e_mstatus);
      lat       = MretLen;
    end else if (fd_code != NO_E) begin
      kind      = 2;
      e_mepc    = fd_pc & ~64'd1;
      e_mcause  = 64'(fd_code);
      if (MtvalEn) e_mtval = fd_pc;
      e_mstatus = trap_ms(e_mstatus);
      e_pc      = csr_mem[MTVEC] & ~64'd3;
      lat       = TrapLen;
    end else if (req) begin
      kind = 3;
    end else begin
      kind = 4;
    end

    i_exception_code_e_m_ff = em_code;
    i_exception_pc_e_m_ff   = em_pc;
    i_exception_addr_e_m_ff = em_addr;
    i_mret_e                = mret;
    i_exception_code_f_d_ff = fd_code;
    i_exception_pc_f_d_ff   = fd_pc;
    i_csr_req               = req;
    i_csr_req_we            = req_we;
    i_csr_req_addr          = req_addr;
    i_csr_req_wdata         = req_wdata;
    #1;
    chk("busy_at_accept", 64'(o_busy), 64'(kind < 3));
    chk("gnt", 64'(o_csr_gnt), 64'(kind == 3));
    if (kind == 3) begin
      chk("req_rdata_prewrite", o_csr_req_rdata, old_req);
      chk("req_we", 64'(o_csr_we), 64'(req_we));
    end
    step();

    if (kind == 3) begin
      clear_inputs();
      chk("req_commit", csr_mem[req_addr], req_we ? req_wdata : old_req);
    end else if (kind == 4) begin
      clear_inputs();
    end else begin
      c = 1;
      // requests and younger exceptions stay asserted while busy and must be ignored
      while (!o_redirect_valid && c < 60) begin
        chk("busy_in_seq", 64'(o_busy), 64'd1);
        chk("no_gnt_in_seq", 64'(o_csr_gnt), 64'd0);
        i_clk_en = !(stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
        step();
        c++;
      end
      i_clk_en = 1'b1;
      chk("redirect_seen", 64'(o_redirect_valid), 64'd1);
      chk("redirect_latency", 64'(c), 64'(lat + stall_len));
      chk("redirect_pc", o_redirect_pc, e_pc);
      chk("busy_in_redirect", 64'(o_busy), 64'd1);
      clear_inputs();
      step();
      chk("idle_after", 64'(o_busy), 64'd0);
      chk("redirect_pulse_one", 64'(o_redirect_valid), 64'd0);
      chk("mepc", csr_mem[MEPC], e_mepc);
      chk("mcause", csr_mem[MCAUSE], e_mcause);
      chk("mtval", csr_mem[MTVAL], e_mtval);
      chk("mstatus", csr_mem[MSTATUS], e_mstatus);
    end
  endtask

  initial begin
    logic [3:0]  r_em, r_fd;
    logic        r_mret, r_req, r_we, seen_redirect;
    int          r_len;
    logic [11:0] r_addr;

    for (int i = 0; i < 4096; i++) csr_mem[i] <= '0;
    clear_inputs();
    i_rst    = 1'b1;
    i_clk_en = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    #1;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_redirect_valid", 64'(o_redirect_valid), 64'd0);
    chk("rst_redirect_pc", o_redirect_pc, 64'd0);
    chk("rst_we", 64'(o_csr_we), 64'd0);
    chk("rst_gnt", 64'(o_csr_gnt), 64'd0);
    step();

    // E/M load fault
    preload(MTVEC, 64'h80000101);
    preload(MSTATUS, 64'h8);
    #1;
    do_txn(4'd5, 64'h80000010, 64'h1003, 1'b0, NO_E, '0, 1'b0, 1'b0, '0, '0, 0, 0);
    chk("tp1_mepc", csr_mem[MEPC], 64'h80000010);
    chk("tp1_mcause", csr_mem[MCAUSE], 64'd5);
    chk("tp1_mtval", csr_mem[MTVAL], MtvalEn ? 64'h1003 : 64'h0);
    chk("tp1_mstatus", csr_mem[MSTATUS], 64'h1880);

    // E/M and F/D in the same cycle
    do_txn(4'd4, 64'h80000200, 64'h2000, 1'b0, 4'd2, 64'h80000300, 1'b0, 1'b0, '0, '0, 0, 0);
    chk("tp2_mcause", csr_mem[MCAUSE], 64'd4);
    chk("tp2_mepc", csr_mem[MEPC], 64'h80000200);

    // mret
    preload(MEPC, 64'h80000044);
    preload(MSTATUS, 64'h80);
    #1;
    do_txn(NO_E, '0, '0, 1'b1, NO_E, '0, 1'b0, 1'b0, '0, '0, 0, 0);
    chk("tp3_mstatus", csr_mem[MSTATUS], 64'h1888);

    // CSR write while idle, then the same request blocked by an F/D exception
    do_txn(NO_E, '0, '0, 1'b0, NO_E, '0, 1'b1, 1'b1, MSCR, 64'hDEAD, 0, 0);
    chk("tp4_mscratch", csr_mem[MSCR], 64'hDEAD);
    do_txn(NO_E, '0, '0, 1'b0, 4'd2, 64'h80000500, 1'b1, 1'b1, MSCR, 64'hBEEF, 0, 0);
    chk("tp5_mscratch_kept", csr_mem[MSCR], 64'hDEAD);
    chk("tp5_mcause", csr_mem[MCAUSE], 64'd2);

    // reset in T_MCAUSE
    preload(MCAUSE, 64'h7);
    #1;
    i_exception_code_e_m_ff = 4'd6;
    i_exception_pc_e_m_ff   = 64'h80000abc;
    i_exception_addr_e_m_ff = 64'h44;
    step();
    clear_inputs();
    step();
    i_rst = 1'b1;
    #1;
    chk("rst_mid_we", 64'(o_csr_we), 64'd0);
    step();
    i_rst = 1'b0;
    #1;
    chk("rst_mid_idle", 64'(o_busy), 64'd0);
    chk("rst_mid_mcause", csr_mem[MCAUSE], 64'h7);
    chk("rst_mid_mepc", csr_mem[MEPC], 64'h80000abc);
    seen_redirect = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen_redirect = seen_redirect | o_redirect_valid;
      step();
    end
    chk("rst_mid_no_redirect", 64'(seen_redirect), 64'd0);

    // clock enable low for 3 cycles mid-trap
    preload(MTVEC, 64'h80000101);
    preload(MSTATUS, 64'h8);
    #1;
    do_txn(4'd5, 64'h80000010, 64'h1003, 1'b0, NO_E, '0, 1'b0, 1'b0, '0, '0, 2, 3);
    chk("tp7_mstatus", csr_mem[MSTATUS], 64'h1880);

    // random transactions
    for (int t = 0; t < 40; t++) begin
      preload(MTVEC, rnd64());
      preload(MEPC, rnd64());
      preload(MSTATUS, rnd64());
      #1;
      r_em   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : NO_E;
      r_fd   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : NO_E;
      r_mret = ($urandom_range(0, 3) == 0);
      r_req  = 1'($urandom_range(0, 1));
      r_we   = 1'($urandom_range(0, 1));
      r_addr = 12'($urandom_range(0, 4095));
      r_len  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      do_txn(r_em, rnd64(), rnd64(), r_mret, r_fd, rnd64(), r_req, r_we, r_addr, rnd64(),
             $urandom_range(1, 2), r_len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
